// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing the RV32-style datapath through
// fetch/decode/execute/memory/writeback, with branch resolution and a retire counter.
module multicycle_ctrl #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [4:0]  status,
   input  logic        mem_ready,
   output logic        pcsrc,
   output logic        alusrc,
   output logic [3:0]  aluop,
   output logic        memrw,
   output logic        wb,
   output logic        regrw,
   output logic [1:0]  immgen_ctrl,
   output logic        pc_en,
   output logic        ir_en,
   output logic        halted,
   output logic        illegal,
   output logic [31:0] instret,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      C_ALU    = 2'd0,
      C_LOAD   = 2'd1,
      C_STORE  = 2'd2,
      C_BRANCH = 2'd3
   } class_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_XOR = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_NOR = 4'b0100;
   localparam logic [3:0] ALU_SL  = 4'b0101;
   localparam logic [3:0] ALU_SR  = 4'b0110;
   localparam logic [3:0] ALU_SUB = 4'b0111;

   state_t     state, state_next;
   class_t     cls_q, dec_cls;
   logic [3:0] aluop_q, dec_aluop, f3_aluop;
   logic       alusrc_q, dec_alusrc, f3_ok;
   logic [1:0] immgen_q, dec_immgen;
   logic [2:0] funct3_q;
   logic       dec_illegal, dec_ecall;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[24:15], instr[11:7], status[4:1]};
   assign state_dbg   = state;

   // Shared funct3 -> ALU operation map for R-type and I-ALU.
   always_comb begin
      f3_aluop = ALU_ADD;
      f3_ok    = 1'b1;
      case (funct3)
         3'b000:  f3_aluop = ALU_ADD;
         3'b001:  f3_aluop = ALU_SL;
         3'b100:  f3_aluop = ALU_XOR;
         3'b101:  f3_aluop = ALU_SR;
         3'b110:  f3_aluop = ALU_OR;
         3'b111:  f3_aluop = ALU_AND;
         default: f3_ok    = 1'b0;
      endcase
   end

   always_comb begin
      dec_cls     = C_ALU;
      dec_aluop   = ALU_ADD;
      dec_alusrc  = 1'b0;
      dec_immgen  = 2'b00;
      dec_illegal = 1'b0;
      dec_ecall   = 1'b0;
      case (opcode)
         OP_R: begin
            dec_illegal = !f3_ok;
            dec_aluop   = f3_aluop;
            if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_aluop = ALU_SUB;
            if (funct3 == 3'b110 && funct7 == 7'b0000001) dec_aluop = ALU_NOR;
         end
         OP_I: begin
            dec_illegal = !f3_ok;
            dec_aluop   = f3_aluop;
            dec_alusrc  = 1'b1;
         end
         OP_LOAD: begin
            dec_cls    = C_LOAD;
            dec_alusrc = 1'b1;
         end
         OP_STORE: begin
            dec_cls    = C_STORE;
            dec_alusrc = 1'b1;
            dec_immgen = 2'b01;
         end
         OP_BRANCH: begin
            dec_cls     = C_BRANCH;
            dec_aluop   = ALU_SUB;
            dec_immgen  = 2'b10;
            dec_illegal = (funct3[2:1] != 2'b00);
         end
         OP_SYSTEM: dec_ecall   = 1'b1;
         default:   dec_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= state_t'(RESET_STATE);
         cls_q    <= C_ALU;
         aluop_q  <= ALU_ADD;
         alusrc_q <= 1'b0;
         immgen_q <= 2'b00;
         funct3_q <= 3'b000;
         halted   <= 1'b0;
         illegal  <= 1'b0;
         instret  <= 32'd0;
      end else begin
         state <= state_next;
         if (state == S_DECODE) begin
            cls_q    <= dec_cls;
            aluop_q  <= dec_aluop;
            alusrc_q <= dec_alusrc;
            immgen_q <= dec_immgen;
            funct3_q <= funct3;
            if (dec_illegal) illegal <= 1'b1;
            if (dec_ecall)   halted  <= 1'b1;
         end
         if (pc_en) instret <= instret + 32'd1;
      end
   end

   // mem_ready is a completion strobe: the access requested in MEM finishes in
   // the cycle it is high; memrw stays asserted until then and is never retracted.
   always_comb begin
      state_next  = state;
      pcsrc       = 1'b0;
      alusrc      = 1'b0;
      aluop       = ALU_ADD;
      memrw       = 1'b0;
      wb          = 1'b0;
      regrw       = 1'b0;
      immgen_ctrl = 2'b00;
      pc_en       = 1'b0;
      ir_en       = 1'b0;
      if (state == S_EXECUTE || state == S_MEM || state == S_WRITEBACK) begin
         alusrc      = alusrc_q;
         aluop       = aluop_q;
         immgen_ctrl = immgen_q;
      end
      case (state)
         S_FETCH: begin
            ir_en      = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            state_next = (dec_illegal || dec_ecall) ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            case (cls_q)
               C_BRANCH: begin
                  pcsrc      = funct3_q[0] ? !status[0] : status[0];
                  pc_en      = 1'b1;
                  state_next = S_FETCH;
               end
               C_LOAD, C_STORE: state_next = S_MEM;
               default:         state_next = S_WRITEBACK;
            endcase
         end
         S_MEM: begin
            if (cls_q == C_STORE) begin
               memrw = 1'b1;
               if (mem_ready) begin
                  pc_en      = 1'b1;
                  state_next = S_FETCH;
               end
            end else if (mem_ready) begin
               state_next = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            regrw      = 1'b1;
            wb         = (cls_q == C_LOAD);
            pc_en      = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
      // Reset masks every strobe so an abandoned instruction leaves no side effect.
      if (rst) begin
         pcsrc       = 1'b0;
         alusrc      = 1'b0;
         aluop       = ALU_ADD;
         memrw       = 1'b0;
         wb          = 1'b0;
         regrw       = 1'b0;
         immgen_ctrl = 2'b00;
         pc_en       = 1'b0;
         ir_en       = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle-sequence model built from the
// instruction-level rules, compared every cycle, plus literal pins for directed cases.
module tb_multicycle_ctrl;
   localparam int W = 47;
   localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4, K_ECALL = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic [4:0]  status = 5'd0;
   logic        mem_ready = 1'b0;
   logic        pcsrc, alusrc, memrw, wb, regrw, pc_en, ir_en, halted, illegal;
   logic [3:0]  aluop;
   logic [1:0]  immgen_ctrl;
   logic [31:0] instret;
   logic [2:0]  state_dbg;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .status(status), .mem_ready(mem_ready),
      .pcsrc(pcsrc), .alusrc(alusrc), .aluop(aluop), .memrw(memrw), .wb(wb),
      .regrw(regrw), .immgen_ctrl(immgen_ctrl), .pc_en(pc_en), .ir_en(ir_en),
      .halted(halted), .illegal(illegal), .instret(instret), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   // Architectural model state
   logic        m_halted = 1'b0;
   logic        m_illegal = 1'b0;
   logic [31:0] m_instret = 32'd0;

   // Per-instruction observations from the compare process
   int         cyc_since_ir = 0, last_cpi = 0;
   int         memrw_cnt = 0, regrw_cnt = 0, pcen_cnt = 0, ir_cnt = 0;
   logic [3:0] obs_aluop = 4'd0;
   logic       obs_alusrc = 1'b0, obs_wb = 1'b0, obs_pcsrc = 1'b0;

   // funct3 -> ALU code; 4'hF marks an undefined encoding
   logic [3:0] f3_op [8] = '{4'h0, 4'h5, 4'hF, 4'hF, 4'h1, 4'h6, 4'h3, 4'h2};

   function automatic logic [W-1:0] mk(input logic pcs, input logic src, input logic [3:0] op,
                                        input logic mw, input logic w_b, input logic rr,
                                        input logic [1:0] im, input logic pe, input logic ie);
      return {pcs, src, op, mw, w_b, rr, im, pe, ie, m_halted, m_illegal, m_instret};
   endfunction

   function automatic logic [W-1:0] mk0();
      return mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
   endfunction

   function automatic void ref_dec(input logic [31:0] ins, output int kind, output logic [3:0] op,
                                   output logic src, output logic [1:0] im);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      kind = K_ILL; op = 4'h0; src = 1'b0; im = 2'b00;
      case (ins[6:0])
         7'b0110011: if (f3_op[f3] != 4'hF) begin
            kind = K_ALU;
            op = f3_op[f3];
            if (f3 == 3'd0 && f7 == 7'h20) op = 4'h7;
            if (f3 == 3'd6 && f7 == 7'h01) op = 4'h4;
         end
         7'b0010011: if (f3_op[f3] != 4'hF) begin kind = K_ALU; op = f3_op[f3]; src = 1'b1; end
         7'b0000011: begin kind = K_LD; src = 1'b1; end
         7'b0100011: begin kind = K_ST; src = 1'b1; im = 2'b01; end
         7'b1100011: if (f3 <= 3'd1) begin kind = K_BR; op = 4'h7; im = 2'b10; end
         7'b1110011: kind = K_ECALL;
         default:    kind = K_ILL;
      endcase
   endfunction

   function automatic logic [31:0] gen(input int kind);
      logic [31:0] r;
      logic [2:0]  legal_f3 [6];
      legal_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      r = $urandom;
      case (kind)
         K_ALU: begin
            r[6:0] = ($urandom_range(0, 1) == 1) ? 7'b0110011 : 7'b0010011;
            r[14:12] = legal_f3[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
               0: r[31:25] = 7'h20;
               1: r[31:25] = 7'h01;
               2: r[31:25] = 7'h00;
               default: ;
            endcase
         end
         K_LD:    r[6:0] = 7'b0000011;
         K_ST:    r[6:0] = 7'b0100011;
         K_BR:    begin r[6:0] = 7'b1100011; r[14:12] = {2'b00, 1'($urandom)}; end
         K_ECALL: r[6:0] = 7'b1110011;
         default: begin
            if ($urandom_range(0, 1) == 1) begin
               r[6:0] = 7'b1100011;
               r[14:12] = 3'($urandom_range(2, 7));
            end else begin
               do r[6:0] = 7'($urandom);
               while (r[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b1110011});
            end
         end
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic step(input logic [31:0] ins, input logic r, input logic mr,
                       input logic [4:0] st, input logic [W-1:0] e);
      @(posedge clk);
      #1;
      instr = ins; rst = r; mem_ready = mr; status = st;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input int n);
      step($urandom, 1'b1, 1'($urandom), 5'($urandom), mk0());
      m_instret = 32'd0; m_halted = 1'b0; m_illegal = 1'b0;
      repeat (n - 1) step($urandom, 1'b1, 1'($urandom), 5'($urandom), mk0());
   endtask

   task automatic run_instr(input logic [31:0] ins, input int w, input logic z,
                            input logic abort_wb, input int halt_cycles);
      int kind;
      logic [3:0] op;
      logic src, mr;
      logic [1:0] im;
      logic [4:0] st;
      ref_dec(ins, kind, op, src, im);
      memrw_cnt = 0; regrw_cnt = 0; pcen_cnt = 0; ir_cnt = 0;
      step(ins, 1'b0, 1'($urandom), 5'($urandom), mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
      step(ins, 1'b0, 1'($urandom), 5'($urandom), mk0());
      if (kind == K_ILL || kind == K_ECALL) begin
         if (kind == K_ILL) m_illegal = 1'b1;
         else m_halted = 1'b1;
         repeat (halt_cycles) step($urandom, 1'b0, 1'($urandom), 5'($urandom), mk0());
         return;
      end
      st = 5'($urandom);
      st[0] = z;
      if (kind == K_BR) begin
         step($urandom, 1'b0, 1'($urandom), st,
              mk(ins[12] ? !z : z, src, op, 1'b0, 1'b0, 1'b0, im, 1'b1, 1'b0));
         m_instret++;
         return;
      end
      step($urandom, 1'b0, 1'($urandom), st, mk(1'b0, src, op, 1'b0, 1'b0, 1'b0, im, 1'b0, 1'b0));
      if (kind == K_LD || kind == K_ST) begin
         for (int i = 0; i <= w; i++) begin
            mr = (i == w);
            step($urandom, 1'b0, mr, 5'($urandom),
                 mk(1'b0, src, op, kind == K_ST, 1'b0, 1'b0, im, kind == K_ST && mr, 1'b0));
         end
      end
      if (kind == K_ST) begin
         m_instret++;
         return;
      end
      if (abort_wb) begin
         step($urandom, 1'b1, 1'($urandom), 5'($urandom), mk0());
         m_instret = 32'd0; m_halted = 1'b0; m_illegal = 1'b0;
         return;
      end
      step($urandom, 1'b0, 1'($urandom), 5'($urandom),
           mk(1'b0, src, op, 1'b0, kind == K_LD, 1'b1, im, 1'b1, 1'b0));
      m_instret++;
   endtask

   task automatic pin(input string name, input int cpi, input int n_memrw, input int n_regrw,
                      input logic [31:0] ret);
      @(negedge clk);
      #1;
      check({name, "_cpi"}, last_cpi, cpi);
      check({name, "_memrw_cycles"}, memrw_cnt, n_memrw);
      check({name, "_regrw_cycles"}, regrw_cnt, n_regrw);
      check({name, "_pc_en_cycles"}, pcen_cnt, 1);
      check({name, "_instret"}, instret, ret);
   endtask

   // Compare process
   always @(negedge clk) begin
      logic [W-1:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl, pc_en, ir_en, halted, illegal, instret};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs t=%0t got=%h want=%h", $time, a, e);
         end
      end
      cyc_since_ir++;
      if (ir_en) begin cyc_since_ir = 0; ir_cnt++; end
      if (memrw) memrw_cnt++;
      if (regrw) begin regrw_cnt++; obs_aluop = aluop; obs_alusrc = alusrc; obs_wb = wb; end
      if (pc_en) begin pcen_cnt++; last_cpi = cyc_since_ir + 1; obs_pcsrc = pcsrc; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      @(posedge clk);
      do_reset(2);

      run_instr(32'h00500093, 0, 1'b0, 1'b0, 0);
      pin("addi", 4, 0, 1, 32'd0);
      check("addi_aluop", 32'(obs_aluop), 32'd0);
      check("addi_alusrc", 32'(obs_alusrc), 32'd1);
      check("addi_wb", 32'(obs_wb), 32'd0);
      run_instr(32'h00112223, 2, 1'b0, 1'b0, 0);
      pin("sw_wait", 6, 3, 0, 32'd1);
      run_instr(32'h00412103, 0, 1'b0, 1'b0, 0);
      pin("lw", 5, 0, 1, 32'd2);
      check("lw_wb", 32'(obs_wb), 32'd1);
      run_instr(32'h00208463, 0, 1'b1, 1'b0, 0);
      pin("beq_taken", 3, 0, 0, 32'd3);
      check("beq_taken_pcsrc", 32'(obs_pcsrc), 32'd1);
      run_instr(32'h00208463, 0, 1'b0, 1'b0, 0);
      pin("beq_not_taken", 3, 0, 0, 32'd4);
      check("beq_not_taken_pcsrc", 32'(obs_pcsrc), 32'd0);
      run_instr(32'h00209463, 0, 1'b1, 1'b0, 0);
      pin("bne_z1", 3, 0, 0, 32'd5);
      check("bne_z1_pcsrc", 32'(obs_pcsrc), 32'd0);
      run_instr(32'h00209463, 0, 1'b0, 1'b0, 0);
      pin("bne_z0", 3, 0, 0, 32'd6);
      check("bne_z0_pcsrc", 32'(obs_pcsrc), 32'd1);

      run_instr(32'h002081B3, 0, 1'b0, 1'b1, 0);
      do_reset(1);
      @(negedge clk);
      #1;
      check("abort_regrw_cycles", regrw_cnt, 0);
      check("abort_instret", instret, 32'd0);
      check("abort_state_fetch", 32'(state_dbg), 32'd0);
      run_instr(32'h002081B3, 0, 1'b0, 1'b0, 0);
      pin("add", 4, 0, 1, 32'd0);
      check("add_aluop", 32'(obs_aluop), 32'd0);
      check("add_alusrc", 32'(obs_alusrc), 32'd0);
      run_instr(32'h402081B3, 0, 1'b0, 1'b0, 0);
      pin("sub", 4, 0, 1, 32'd1);
      check("sub_aluop", 32'(obs_aluop), 32'd7);

      run_instr(32'hFFFFFFFF, 0, 1'b0, 1'b0, 5);
      @(negedge clk);
      #1;
      check("illegal_flag", 32'(illegal), 32'd1);
      check("illegal_halted", 32'(halted), 32'd0);
      check("illegal_pc_en_cycles", pcen_cnt, 0);
      check("illegal_ir_en_cycles", ir_cnt, 1);
      do_reset(2);
      run_instr(32'h00000073, 0, 1'b0, 1'b0, 4);
      @(negedge clk);
      #1;
      check("ecall_halted", 32'(halted), 32'd1);
      check("ecall_illegal", 32'(illegal), 32'd0);
      do_reset(2);

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 35)      run_instr(gen(K_ALU), 0, 1'($urandom), 1'b0, 0);
         else if (r < 50) run_instr(gen(K_LD), $urandom_range(0, 3), 1'($urandom), 1'b0, 0);
         else if (r < 65) run_instr(gen(K_ST), $urandom_range(0, 3), 1'($urandom), 1'b0, 0);
         else if (r < 85) run_instr(gen(K_BR), 0, 1'($urandom), 1'b0, 0);
         else if (r < 90) begin
            run_instr(gen(K_ALU), 0, 1'b0, 1'b1, 0);
            do_reset($urandom_range(1, 2));
         end else begin
            run_instr(gen(r < 95 ? K_ILL : K_ECALL), 0, 1'b0, 1'b0, $urandom_range(1, 4));
            do_reset($urandom_range(1, 3));
         end
      end

      @(negedge clk);
      #1;
      check("expected_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
